// File: rtl/neg_latch_pkg.sv
// Shared definitions for the clock-phase latch library.
`timescale 1ns/1ps
package neg_latch_pkg;

    // Latch enable is active-low: the low clock phase opens the latch.
    typedef enum logic {
        PHASE_OPEN = 1'b0,
        PHASE_HOLD = 1'b1
    } phase_e;

    localparam logic LATCH_RESET_BIT = 1'b0;

endpackage

// File: rtl/neg_latch_bit.sv
// One-bit negative-transparent latch cell with reset honoured only while open.
`timescale 1ns/1ps
module neg_latch_bit
    import neg_latch_pkg::*;
#(
    parameter logic RESET_VAL = LATCH_RESET_BIT
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    phase_e phase;
    assign phase = phase_e'(clk);

    // Hold has priority, so reset cannot disturb q during the high phase.
    always_latch begin
        if (phase == PHASE_OPEN) begin
            if (!rst) begin
                q <= RESET_VAL;
            end else begin
                q <= d;
            end
        end
    end

endmodule

// File: rtl/neg_latch.sv
// WIDTH-bit negative-transparent D latch built from per-bit cells.
`timescale 1ns/1ps
module neg_latch
    import neg_latch_pkg::*;
#(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{LATCH_RESET_BIT}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        neg_latch_bit #(
            .RESET_VAL (RESET_VAL[i])
        ) u_cell (
            .clk (clk),
            .rst (rst),
            .d   (d[i]),
            .q   (q[i])
        );
    end

endmodule

// File: tb/tb_neg_latch.sv
// Directed bench for neg_latch: scalar instance and an 8-bit instance with a nonzero reset value.
`timescale 1ns/1ps
module tb_neg_latch;

    logic       clk;
    logic       rst;
    logic [0:0] d;
    logic [0:0] q;
    logic       rst8;
    logic [7:0] d8;
    logic [7:0] q8;

    int checks = 0;
    int errors = 0;

    neg_latch #(
        .WIDTH     (1),
        .RESET_VAL (1'b0)
    ) dut1 (
        .clk (clk),
        .rst (rst),
        .d   (d),
        .q   (q)
    );

    neg_latch #(
        .WIDTH     (8),
        .RESET_VAL (8'hA5)
    ) dut8 (
        .clk (clk),
        .rst (rst8),
        .d   (d8),
        .q   (q8)
    );

    // Low first: low 0-5, high 5-10, low 10-15, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    initial begin
        rst  = 1'b0;
        d    = 1'b0;
        rst8 = 1'b0;
        d8   = 8'hFF;
        #2;                                   // t=2, low
        check("reset_low", {7'b0, q}, 8'h00);
        check("w8_reset_val", q8, 8'hA5);
        #1 d = 1'b1;                          // t=3
        #1;                                   // t=4
        check("reset_ignores_d", {7'b0, q}, 8'h00);
        #3;                                   // t=7, high
        rst  = 1'b1;
        rst8 = 1'b1;
        d8   = 8'h3C;
        #1;                                   // t=8
        check("hold_after_release", {7'b0, q}, 8'h00);
        check("w8_hold_reset_val", q8, 8'hA5);
        #3;                                   // t=11, low
        check("follow_open", {7'b0, q}, 8'h01);
        check("w8_follow", q8, 8'h3C);
        #1 d = 1'b0;                          // t=12
        #1;                                   // t=13
        check("follow_d", {7'b0, q}, 8'h00);
        #4;                                   // t=17, high
        d  = 1'b1;
        d8 = 8'h00;
        #1;                                   // t=18
        check("hold_ignores_d", {7'b0, q}, 8'h00);
        check("w8_hold", q8, 8'h3C);
        #3;                                   // t=21, low
        check("open_after_hold", {7'b0, q}, 8'h01);
        check("w8_open_after_hold", q8, 8'h00);
        #1 d8 = 8'h5A;                        // t=22
        #1;                                   // t=23
        check("w8_follow_5a", q8, 8'h5A);
        #3 rst = 1'b0;                        // t=26, high
        #1;                                   // t=27
        check("rst_in_hold", {7'b0, q}, 8'h01);
        #1 rst = 1'b1;                        // t=28
        #3;                                   // t=31, low
        check("rst_pulse_high_ignored", {7'b0, q}, 8'h01);
        #5 rst = 1'b0;                        // t=36, high
        #2;                                   // t=38
        check("rst_held_in_hold", {7'b0, q}, 8'h01);
        #3;                                   // t=41, low
        check("rst_across_fall", {7'b0, q}, 8'h00);
        #1 rst = 1'b1;                        // t=42
        #1;                                   // t=43
        check("rst_release_open", {7'b0, q}, 8'h01);
        #8 rst = 1'b0;                        // t=51, low
        #1;                                   // t=52
        check("rst_mid_open", {7'b0, q}, 8'h00);
        #1 rst = 1'b1;                        // t=53
        #1;                                   // t=54
        check("rst_release_mid_open", {7'b0, q}, 8'h01);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
